// File: rtl/run_sequencer.sv
// Host-to-processor run sequencer: start pulse, RUN cycle counting, result handshake.
// Define RUN_SEQUENCER_TIMEOUT_EN to compile in the RUN watchdog.
module run_sequencer #(
   parameter int unsigned START_CYCLES = 2,
   parameter logic [15:0] TIMEOUT_CYC  = 16'd50000
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        ReqValid,
   output logic        ReqReady,
   input  logic        Abort,
   output logic        DutStart,
   input  logic        DutAck,
   output logic        DoneValid,
   input  logic        DoneReady,
   output logic [15:0] CycleCount,
   output logic        TimedOut,
   output logic        Busy
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned START_W = 4;
   localparam logic [START_W-1:0] START_LAST = START_W'(START_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

   typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [START_W-1:0] start_cnt;
   logic [CNT_W-1:0]   cycle_cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic               run_entry;
   logic               run_count;
   logic               timeout_hit;

   // Saturating increment; the counter parks at all-ones rather than wrapping.
   assign cnt_inc   = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_W'(1);
   assign run_entry = (state == START) && (state_nxt == RUN);
   assign run_count = (state == RUN) && !Abort && !DutAck;

`ifdef RUN_SEQUENCER_TIMEOUT_EN
   logic timed_out;

   assign timeout_hit = (cnt_inc == TIMEOUT_CYC);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         timed_out <= 1'b0;
      end else if (run_entry) begin
         timed_out <= 1'b0;
      end else if (run_count && timeout_hit) begin
         timed_out <= 1'b1;
      end
   end

   assign TimedOut = timed_out;
`else
   assign timeout_hit = 1'b0;
   assign TimedOut    = 1'b0;
`endif

   // State register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state; Abort outranks Ack and the watchdog, Ack outranks the watchdog
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (ReqValid) state_nxt = START;
         START: begin
            if (Abort)                         state_nxt = IDLE;
            else if (start_cnt == START_LAST)  state_nxt = RUN;
         end
         RUN: begin
            if (Abort)                         state_nxt = IDLE;
            else if (DutAck || timeout_hit)    state_nxt = DONE;
         end
         DONE:  if (DoneReady) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Start-pulse width and RUN cycle counters
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         start_cnt <= '0;
         cycle_cnt <= '0;
      end else begin
         start_cnt <= (state == START) ? start_cnt + START_W'(1) : '0;
         if (run_entry) begin
            cycle_cnt <= '0;
         end else if (run_count) begin
            cycle_cnt <= cnt_inc;
         end
      end
   end

   // Outputs decoded from state
   always_comb begin
      ReqReady  = 1'b0;
      DutStart  = 1'b0;
      DoneValid = 1'b0;
      Busy      = 1'b0;
      case (state)
         IDLE:  ReqReady = 1'b1;
         START: begin
            DutStart = 1'b1;
            Busy     = 1'b1;
         end
         RUN:   Busy = 1'b1;
         DONE:  DoneValid = 1'b1;
         default: ReqReady = 1'b0;
      endcase
   end

   assign CycleCount = cycle_cnt;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: vector table, directed corner cases, random runs
// against a run-level reference model.
module tb_run_sequencer;

   localparam int unsigned START_CYCLES = 2;
   localparam logic [15:0] TIMEOUT_CYC  = 16'd100;

   logic        Clk       = 1'b0;
   logic        Reset_n   = 1'b0;
   logic        ReqValid  = 1'b0;
   logic        ReqReady;
   logic        Abort     = 1'b0;
   logic        DutStart;
   logic        DutAck    = 1'b1;
   logic        DoneValid;
   logic        DoneReady = 1'b0;
   logic [15:0] CycleCount;
   logic        TimedOut;
   logic        Busy;

   int total = 0;
   int bad   = 0;

   run_sequencer #(
      .START_CYCLES(START_CYCLES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .ReqValid  (ReqValid),
      .ReqReady  (ReqReady),
      .Abort     (Abort),
      .DutStart  (DutStart),
      .DutAck    (DutAck),
      .DoneValid (DoneValid),
      .DoneReady (DoneReady),
      .CycleCount(CycleCount),
      .TimedOut  (TimedOut),
      .Busy      (Busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int ack_at;     // RUN clock (1-based) on which Ack first rises
      int abort_at;   // RUN clock carrying Abort, 0 = none
      bit exp_done;
      int exp_count;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_ready"},   ReqReady,   1);
      check({tag, "_dut_start"},   DutStart,   0);
      check({tag, "_done_valid"},  DoneValid,  0);
      check({tag, "_busy"},        Busy,       0);
      check({tag, "_cycle_count"}, CycleCount, 0);
      check({tag, "_timed_out"},   TimedOut,   0);
   endtask

   // From IDLE at a negedge: request, measure the start pulse, return at the negedge before RUN clock 1.
   task automatic start_run(input bit stale);
      int width;
      check("req_ready_before_start", ReqReady, 1);
      ReqValid = 1'b1;
      DutAck   = stale;
      step();
      ReqValid = 1'b0;
      width    = 0;
      while (DutStart === 1'b1 && width < 20) begin
         width++;
         DutAck = stale ? 1'($urandom_range(0, 1)) : 1'b0;
         step();
      end
      check("start_width", width, START_CYCLES);
      check("run_entry_busy", Busy, 1);
      check("run_entry_no_done", DoneValid, 0);
      DutAck = 1'b0;
   endtask

   // Drive RUN clocks up to the expected terminating one and check the outcome.
   task automatic run_body(input int ack_at, input int abort_at, input bit exp_done, input int exp_count);
      int term;
      term = exp_done ? ack_at : abort_at;
      for (int i = 1; i <= term; i++) begin
         DutAck = (i >= ack_at);
         Abort  = (i == abort_at);
         step();
         Abort = 1'b0;
         if (i < term) check("run_still_busy", {DoneValid, Busy}, 2'b01);
      end
      DutAck = 1'b0;
      check("run_end_done_valid", DoneValid, exp_done);
      check("run_end_req_ready", ReqReady, !exp_done);
      check("run_end_dut_start", DutStart, 0);
      if (exp_done) begin
         check("run_end_cycle_count", CycleCount, exp_count);
         check("run_end_timed_out", TimedOut, 0);
      end
   endtask

   // Hold the result for a while with noise on ignored inputs, then consume it.
   task automatic finish_done(input int hold, input int exp_count, input bit exp_to);
      for (int h = 0; h < hold; h++) begin
         DoneReady = 1'b0;
         DutAck    = 1'($urandom_range(0, 1));
         Abort     = 1'($urandom_range(0, 1));
         ReqValid  = 1'($urandom_range(0, 1));
         step();
         check("done_held_valid", DoneValid, 1);
         check("done_held_count", CycleCount, exp_count);
         check("done_held_timed_out", TimedOut, exp_to);
      end
      DoneReady = 1'b1;
      Abort     = 1'($urandom_range(0, 1));
      ReqValid  = 1'($urandom_range(0, 1));
      step();
      DoneReady = 1'b0;
      ReqValid  = 1'b0;
      Abort     = 1'b0;
      DutAck    = 1'b0;
      check("done_exit_idle", {ReqReady, Busy, DoneValid, DutStart}, 4'b1000);
   endtask

   task automatic idle_gap(input int n);
      for (int k = 0; k < n; k++) begin
         DutAck = 1'($urandom_range(0, 1));
         Abort  = 1'($urandom_range(0, 1));
         step();
         check("idle_stays_idle", {ReqReady, Busy, DoneValid}, 3'b100);
      end
      DutAck = 1'b0;
      Abort  = 1'b0;
   endtask

   // Run-level reference: a run yields a result unless Abort arrives no later than the Ack clock.
   task automatic scenario(input int ack_at, input int abort_at, input bit stale);
      bit exp_done;
      int exp_count;
      exp_done  = (abort_at == 0) || (abort_at > ack_at);
      exp_count = ack_at - 1;
      start_run(stale);
      run_body(ack_at, abort_at, exp_done, exp_count);
      if (exp_done) finish_done($urandom_range(0, 4), exp_count, 1'b0);
      idle_gap($urandom_range(0, 3));
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      int   n;
      int   done_seen;

      vecs = '{
         '{38, 0, 1'b1, 37},
         '{ 1, 0, 1'b1,  0},
         '{ 2, 0, 1'b1,  1},
         '{ 5, 5, 1'b0,  0},
         '{10, 3, 1'b0,  0},
         '{ 4, 9, 1'b1,  3},
         '{ 1, 1, 1'b0,  0}
      };

      // Reset with a stale Ack present
      #1;
      check_reset_values("reset");
      @(negedge Clk);
      @(negedge Clk);
      check_reset_values("reset_held");
      Reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         DutAck = 1'b1;
         step();
         check("idle_ack_ignored", {ReqReady, Busy, DoneValid}, 3'b100);
      end
      DutAck = 1'b0;

      // Vector table
      for (int v = 0; v < 7; v++) begin
         start_run(1'b1);
         run_body(vecs[v].ack_at, vecs[v].abort_at, vecs[v].exp_done, vecs[v].exp_count);
         if (vecs[v].exp_done) finish_done(3, vecs[v].exp_count, 1'b0);
         idle_gap(1);
      end

      // Consume result with ReqValid held: accept only one clock after DONE exits
      start_run(1'b0);
      run_body(3, 0, 1'b1, 2);
      DoneReady = 1'b1;
      ReqValid  = 1'b1;
      step();
      DoneReady = 1'b0;
      check("consume_no_same_clock_accept", {ReqReady, DutStart, Busy}, 3'b100);
      step();
      ReqValid = 1'b0;
      check("accept_next_clock", {ReqReady, DutStart, Busy}, 3'b011);
      Abort = 1'b1;
      step();
      Abort = 1'b0;
      check("abort_in_start", {ReqReady, DutStart, Busy, DoneValid}, 4'b1000);

`ifdef RUN_SEQUENCER_TIMEOUT_EN
      // Watchdog fires after TIMEOUT_CYC Ack-low RUN clocks
      start_run(1'b0);
      n = 0;
      while (DoneValid !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      check("timeout_run_clocks", n, TIMEOUT_CYC);
      check("timeout_cycle_count", CycleCount, TIMEOUT_CYC);
      check("timeout_flag", TimedOut, 1);
      finish_done(2, TIMEOUT_CYC, 1'b1);
      // Ack on the watchdog clock wins
      start_run(1'b0);
      run_body(TIMEOUT_CYC, 0, 1'b1, TIMEOUT_CYC - 1);
      finish_done(1, TIMEOUT_CYC - 1, 1'b0);
      done_seen = 0;
`else
      // No watchdog: wait well past counter saturation, then Ack reports all-ones
      start_run(1'b0);
      done_seen = 0;
      n = 0;
      for (int k = 0; k < 70000; k++) begin
         step();
         if (DoneValid === 1'b1) done_seen++;
         n++;
      end
      check("no_timeout_done_seen", done_seen, 0);
      check("no_timeout_still_busy", Busy, 1);
      DutAck = 1'b1;
      step();
      DutAck = 1'b0;
      check("saturated_done_valid", DoneValid, 1);
      check("saturated_cycle_count", CycleCount, 16'hFFFF);
      check("saturated_timed_out", TimedOut, 0);
      finish_done(1, 16'hFFFF, 1'b0);
`endif

      // Asynchronous reset pulse mid-RUN, between clock edges
      start_run(1'b0);
      step();
      step();
      step();
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check_reset_values("async_reset");
      #1;
      Reset_n = 1'b1;
      @(negedge Clk);
      check("after_async_reset", {ReqReady, Busy, DoneValid}, 3'b100);
      done_seen = 0;
      for (int k = 0; k < 5; k++) begin
         DutAck = 1'b1;
         step();
         if (DoneValid === 1'b1) done_seen++;
      end
      DutAck = 1'b0;
      check("no_result_after_reset", done_seen, 0);

      // Randomised runs
      for (int r = 0; r < 40; r++) begin
         int ack_at;
         int abort_at;
         ack_at   = $urandom_range(1, 60);
         abort_at = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60));
         scenario(ack_at, abort_at, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter START_CYCLES, default 2, the DutStart pulse width in clocks (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16'd50000, the watchdog limit in RUN cycles.
REQ-003 SHALL have port Clk  input  1  the single clock; all state updates on posedge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ReqValid  input  1  host requests one program run.
REQ-006 SHALL have port ReqReady  output  1  sequencer can accept a request.
REQ-007 SHALL have port Abort  input  1  host cancels the run in progress.
REQ-008 SHALL have port DutStart  output  1  drives the processor Start input.
REQ-009 SHALL have port DutAck  input  1  processor done flag (combinational; may be high while idle).
REQ-010 SHALL have port DoneValid  output  1  a run result is presented.
REQ-011 SHALL have port DoneReady  input  1  host consumes the result.
REQ-012 SHALL have port CycleCount  output  16  clocks spent in RUN for the presented result.
REQ-013 SHALL have port TimedOut  output  1  the presented result ended by the watchdog.
REQ-014 SHALL have port Busy  output  1  high in START or RUN.

Function
REQ-015 SHALL implement FSM states IDLE, START, RUN, DONE; all outputs registered or decoded from state only.
REQ-016 SHALL drive ReqReady=1 only in IDLE; a request is accepted on a clock with ReqValid&&ReqReady, moving IDLE->START.
REQ-017 SHALL hold DutStart=1 for exactly START_CYCLES clocks in START, then move to RUN with DutStart=0.
REQ-018 SHALL ignore DutAck in IDLE, START, and DONE; a stale Ack from a prior program never completes a run.
REQ-019 SHALL clear the cycle counter on entry to RUN and increment it by 1 on each RUN clock where DutAck=0.
REQ-020 SHALL, on a RUN clock with DutAck=1, move to DONE with CycleCount equal to the number of preceding RUN clocks (0 if Ack is high on the first RUN clock) and TimedOut=0.
REQ-021 SHALL saturate the counter at 16'hFFFF, never wrapping.
REQ-022 SHALL assert DoneValid only in DONE, holding CycleCount and TimedOut stable until DoneReady=1, then return to IDLE the next clock.
REQ-023 SHALL NOT accept a new request in the same clock that DONE is consumed; the earliest accept is the following clock.
REQ-024 SHALL, on Abort=1 in START or RUN, return to IDLE next clock with DutStart=0 and produce no result; Abort is ignored in IDLE and DONE.
REQ-025 SHALL give Abort priority over DutAck and the timeout when they coincide.

Reset
REQ-026 SHALL, on Reset_n=0, immediately force state IDLE, ReqReady=1, DutStart=0, DoneValid=0, Busy=0, CycleCount=0, TimedOut=0, start-width counter=0.
REQ-027 SHALL discard any run in progress when reset is asserted mid-operation; no result is produced.
REQ-028 SHALL leave IDLE no earlier than the first posedge after Reset_n rises.

Configuration
REQ-029 SHALL use macro RUN_SEQUENCER_TIMEOUT_EN to compile the watchdog in or out.
REQ-030 SHALL, with the macro defined, move RUN->DONE with TimedOut=1 and CycleCount=TIMEOUT_CYC when the counter reaches TIMEOUT_CYC with DutAck=0; DutAck=1 on that same clock wins (TimedOut=0).
REQ-031 SHALL, without the macro, contain no watchdog logic, tie TimedOut to 0, and wait in RUN indefinitely (counter saturated).

Verification
REQ-032 SHALL cover: DutAck=1 during reset and IDLE, ReqValid pulse -> DutStart high exactly 2 clocks, no completion until RUN.
REQ-033 SHALL cover: Ack raised on the 38th RUN clock -> DoneValid with CycleCount=37, TimedOut=0; held until DoneReady.
REQ-034 SHALL cover: macro defined, TIMEOUT_CYC=100, Ack never rises -> CycleCount=100, TimedOut=1; macro undefined -> no DoneValid after 70000 clocks, CycleCount saturates at 16'hFFFF internally.
REQ-035 SHALL cover: Abort on the 5th RUN clock with Ack also high -> IDLE, no DoneValid, ReqReady=1 next clock.
REQ-036 SHALL cover: DoneReady=1 with ReqValid=1 held -> request accepted one clock after DONE exits, not the same clock.
REQ-037 SHALL cover: Reset_n pulsed low mid-RUN between clock edges -> outputs reach reset values asynchronously, no result emitted.
